// File: rtl/croc_pad_ctrl.sv
// croc_pad_ctrl: per-pad function select, open-drain drive,
// input sync/glitch filter and edge events for the croc pad ring.
module croc_pad_ctrl #(
  parameter int unsigned NumPads    = 30,
  parameter int unsigned NumAltFn   = 2,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned AddrW      = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_req_i,
  input  logic                         cfg_we_i,
  input  logic [AddrW-1:0]             cfg_addr_i,
  input  logic [7:0]                   cfg_wdata_i,
  output logic [7:0]                   cfg_rdata_o,
  output logic                         cfg_rvalid_o,
  input  logic [NumPads-1:0]           gpio_o_i,
  input  logic [NumPads-1:0]           gpio_en_i,
  output logic [NumPads-1:0]           gpio_i_o,
  input  logic [NumAltFn*NumPads-1:0]  alt_o_i,
  input  logic [NumAltFn*NumPads-1:0]  alt_en_i,
  output logic [NumAltFn*NumPads-1:0]  alt_i_o,
  output logic [NumPads-1:0]           rise_o,
  output logic [NumPads-1:0]           fall_o,
  output logic [NumPads-1:0]           pad_c2p_o,
  output logic [NumPads-1:0]           pad_c2p_en_o,
  input  logic [NumPads-1:0]           pad_p2c_i
);

  localparam logic [7:0] CfgRst = 8'h03;

  logic [7:0]            cfg_q [NumPads];
  logic [NumPads-1:0]    wr_hit;
  logic                  addr_ok;
  logic                  wr_en;
  logic                  rd_en;
  logic [7:0]            rd_cfg;
  logic [7:0]            rdata_q;
  logic                  rvalid_q;

  logic [1:0]            sel [NumPads];
  logic [NumPads-1:0]    od;
  logic [NumPads-1:0]    flt_en;
  logic [3:0]            thr [NumPads];

  logic [NumPads-1:0]    d;
  logic [NumPads-1:0]    e;
  logic [NumPads-1:0]    c2p_q;
  logic [NumPads-1:0]    c2p_en_q;

  logic [SyncStages-1:0] sync_q [NumPads];
  logic [NumPads-1:0]    s;
  logic [NumPads-1:0]    f_q;
  logic [NumPads-1:0]    f_d_q;
  logic [3:0]            cnt_q [NumPads];

  assign addr_ok = 32'(cfg_addr_i) < 32'(NumPads);
  assign wr_en   = cfg_req_i & cfg_we_i & addr_ok;
  assign rd_en   = cfg_req_i & ~cfg_we_i;

  // decode write strobe per pad and pick read data for the address
  always_comb begin
    wr_hit = '0;
    rd_cfg = 8'h00;
    for (int i = 0; i < int'(NumPads); i++) begin
      if (32'(cfg_addr_i) == 32'(i)) begin
        wr_hit[i] = wr_en;
        rd_cfg    = cfg_q[i];
      end
    end
  end

  // configuration registers, reset to safe hi-Z
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumPads); i++) cfg_q[i] <= CfgRst;
    end else begin
      for (int i = 0; i < int'(NumPads); i++) begin
        if (wr_hit[i]) cfg_q[i] <= cfg_wdata_i;
      end
    end
  end

  // read response, data held while no read is returned
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= addr_ok ? rd_cfg : 8'h00;
    end
  end

  assign cfg_rdata_o  = rdata_q;
  assign cfg_rvalid_o = rvalid_q;

  // split config fields per pad
  always_comb begin
    for (int i = 0; i < int'(NumPads); i++) begin
      sel[i]    = cfg_q[i][1:0];
      od[i]     = cfg_q[i][2];
      flt_en[i] = cfg_q[i][3];
      thr[i]    = cfg_q[i][7:4];
    end
  end

  // source mux: GPIO, alternate function, or safe (0,0)
  always_comb begin
    d = '0;
    e = '0;
    for (int i = 0; i < int'(NumPads); i++) begin
      if (sel[i] == 2'd0) begin
        d[i] = gpio_o_i[i];
        e[i] = gpio_en_i[i];
      end
      for (int k = 0; k < int'(NumAltFn); k++) begin
        if (32'(sel[i]) == 32'(k + 1)) begin
          d[i] = alt_o_i[k*NumPads+i];
          e[i] = alt_en_i[k*NumPads+i];
        end
      end
    end
  end

  // registered pad drive; open-drain only ever pulls low
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c2p_q    <= '0;
      c2p_en_q <= '0;
    end else begin
      c2p_q    <= d & ~od;
      c2p_en_q <= e & ~(od & d);
    end
  end

  assign pad_c2p_o    = c2p_q;
  assign pad_c2p_en_o = c2p_en_q;

  // input synchroniser chain per pad
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumPads); i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NumPads); i++) begin
        sync_q[i] <= {sync_q[i][SyncStages-2:0], pad_p2c_i[i]};
      end
    end
  end

  // synchronised pad level per pad
  always_comb begin
    for (int i = 0; i < int'(NumPads); i++) s[i] = sync_q[i][SyncStages-1];
  end

  // glitch filter: a change must persist thr+1 cycles to be taken
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      f_q <= '0;
      for (int i = 0; i < int'(NumPads); i++) cnt_q[i] <= 4'd0;
    end else begin
      for (int i = 0; i < int'(NumPads); i++) begin
        if (wr_hit[i]) begin
          cnt_q[i] <= 4'd0;
        end else if (!flt_en[i]) begin
          f_q[i]   <= s[i];
          cnt_q[i] <= 4'd0;
        end else if (s[i] == f_q[i]) begin
          cnt_q[i] <= 4'd0;
        end else if (cnt_q[i] >= thr[i]) begin
          f_q[i]   <= s[i];
          cnt_q[i] <= 4'd0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // delayed filtered value for edge events
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) f_d_q <= '0;
    else       f_d_q <= f_q;
  end

  assign rise_o   = f_q & ~f_d_q;
  assign fall_o   = ~f_q & f_d_q;
  assign gpio_i_o = f_q;

  // route filtered input only to the selected alternate function
  always_comb begin
    alt_i_o = '0;
    for (int k = 0; k < int'(NumAltFn); k++) begin
      for (int i = 0; i < int'(NumPads); i++) begin
        alt_i_o[k*NumPads+i] = f_q[i] & (32'(sel[i]) == 32'(k + 1));
      end
    end
  end

endmodule

// File: tb/tb_croc_pad_ctrl.sv
// tb_croc_pad_ctrl: directed checks of mux, open-drain,
// filter, edge events, config port and async reset.
module tb_croc_pad_ctrl;

  localparam int NP = 30;
  localparam int NA = 2;
  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cfg_req_i;
  logic          cfg_we_i;
  logic [AW-1:0] cfg_addr_i;
  logic [7:0]    cfg_wdata_i;
  logic [7:0]    cfg_rdata_o;
  logic          cfg_rvalid_o;
  logic [NP-1:0] gpio_o_i;
  logic [NP-1:0] gpio_en_i;
  logic [NP-1:0] gpio_i_o;
  logic [NA*NP-1:0] alt_o_i;
  logic [NA*NP-1:0] alt_en_i;
  logic [NA*NP-1:0] alt_i_o;
  logic [NP-1:0] rise_o;
  logic [NP-1:0] fall_o;
  logic [NP-1:0] pad_c2p_o;
  logic [NP-1:0] pad_c2p_en_o;
  logic [NP-1:0] pad_p2c_i;

  int n_chk = 0;
  int n_err = 0;

  croc_pad_ctrl #(
    .NumPads(NP), .NumAltFn(NA), .SyncStages(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i),
    .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_rdata_o(cfg_rdata_o), .cfg_rvalid_o(cfg_rvalid_o),
    .gpio_o_i(gpio_o_i), .gpio_en_i(gpio_en_i),
    .gpio_i_o(gpio_i_o),
    .alt_o_i(alt_o_i), .alt_en_i(alt_en_i),
    .alt_i_o(alt_i_o),
    .rise_o(rise_o), .fall_o(fall_o),
    .pad_c2p_o(pad_c2p_o), .pad_c2p_en_o(pad_c2p_en_o),
    .pad_p2c_i(pad_p2c_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_wr(input int a, input logic [7:0] v);
    cfg_req_i   = 1'b1;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = AW'(a);
    cfg_wdata_i = v;
    tick();
    cfg_req_i   = 1'b0;
    cfg_we_i    = 1'b0;
  endtask

  task automatic cfg_rd(input int a, input logic [7:0] exp,
                        input string tag);
    cfg_req_i  = 1'b1;
    cfg_we_i   = 1'b0;
    cfg_addr_i = AW'(a);
    tick();
    cfg_req_i  = 1'b0;
    check({tag, "_rvalid"}, 32'(cfg_rvalid_o), 32'd1);
    check(tag, 32'(cfg_rdata_o), 32'(exp));
  endtask

  initial begin
    rst_i       = 1'b1;
    cfg_req_i   = 1'b0;
    cfg_we_i    = 1'b0;
    cfg_addr_i  = '0;
    cfg_wdata_i = '0;
    gpio_o_i    = '0;
    gpio_en_i   = '1;
    alt_o_i     = '0;
    alt_en_i    = '0;
    pad_p2c_i   = '0;
    #1;
    check("rst_c2p_en", 32'(pad_c2p_en_o), 32'd0);
    check("rst_rvalid", 32'(cfg_rvalid_o), 32'd0);
    check("rst_rdata", 32'(cfg_rdata_o), 32'd0);
    check("rst_gpio_i", 32'(gpio_i_o), 32'd0);
    repeat (2) tick();
    rst_i = 1'b0;
    tick();

    // every pad starts safe; nothing drives despite gpio_en
    for (int i = 0; i < NP; i++) cfg_rd(i, 8'h03, "rst_cfg");
    tick();
    check("safe_c2p_en", 32'(pad_c2p_en_o), 32'd0);
    check("idle_rvalid", 32'(cfg_rvalid_o), 32'd0);

    // pad 5 on alternate function 0
    alt_o_i[5]  = 1'b1;
    alt_en_i[5] = 1'b1;
    cfg_wr(5, 8'h01);
    check("mux_lat1", 32'(pad_c2p_en_o[5]), 32'd0);
    tick();
    check("mux_c2p", 32'(pad_c2p_o[5]), 32'd1);
    check("mux_c2p_en", 32'(pad_c2p_en_o[5]), 32'd1);
    alt_o_i[5] = 1'b0;
    tick();
    check("mux_src_chg", 32'(pad_c2p_o[5]), 32'd0);
    alt_o_i[5] = 1'b1;
    pad_p2c_i[5] = 1'b1;
    tick();
    tick();
    check("mux_in_early", 32'(alt_i_o[5]), 32'd0);
    tick();
    check("mux_alt0_in", 32'(alt_i_o[5]), 32'd1);
    check("mux_alt1_in", 32'(alt_i_o[NP+5]), 32'd0);
    check("mux_gpio_in", 32'(gpio_i_o[5]), 32'd1);
    cfg_wr(5, 8'h03);
    tick();
    check("safe_c2p_en5", 32'(pad_c2p_en_o[5]), 32'd0);
    check("safe_c2p5", 32'(pad_c2p_o[5]), 32'd0);
    check("safe_alt_in", 32'(alt_i_o[5]), 32'd0);
    check("safe_gpio_in", 32'(gpio_i_o[5]), 32'd1);

    // pad 0 open-drain on GPIO
    cfg_wr(0, 8'h04);
    tick();
    check("od_low_en", 32'(pad_c2p_en_o[0]), 32'd1);
    check("od_low_c2p", 32'(pad_c2p_o[0]), 32'd0);
    gpio_o_i[0] = 1'b1;
    tick();
    check("od_high_en", 32'(pad_c2p_en_o[0]), 32'd0);
    check("od_high_c2p", 32'(pad_c2p_o[0]), 32'd0);

    // pad 2 filter thr=3: 3-cycle pulse rejected
    cfg_wr(2, 8'h38);
    pad_p2c_i[2] = 1'b1;
    repeat (3) tick();
    pad_p2c_i[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check("flt_glitch", 32'(gpio_i_o[2]), 32'd0);
      check("flt_glitch_rise", 32'(rise_o[2]), 32'd0);
      tick();
    end
    // held high: taken after 2 + 3 + 1 = 6 cycles
    pad_p2c_i[2] = 1'b1;
    repeat (5) tick();
    check("flt_5cyc", 32'(gpio_i_o[2]), 32'd0);
    tick();
    check("flt_6cyc", 32'(gpio_i_o[2]), 32'd1);
    check("flt_rise", 32'(rise_o[2]), 32'd1);
    tick();
    check("flt_rise_1cyc", 32'(rise_o[2]), 32'd0);
    check("flt_hold", 32'(gpio_i_o[2]), 32'd1);

    // pad 7 filter off: follows after 3 cycles
    pad_p2c_i[7] = 1'b1;
    repeat (2) tick();
    check("nf_rise_early", 32'(gpio_i_o[7]), 32'd0);
    tick();
    check("nf_high", 32'(gpio_i_o[7]), 32'd1);
    check("nf_rise", 32'(rise_o[7]), 32'd1);
    tick();
    check("nf_rise_end", 32'(rise_o[7]), 32'd0);
    pad_p2c_i[7] = 1'b0;
    repeat (3) tick();
    check("nf_low", 32'(gpio_i_o[7]), 32'd0);
    check("nf_fall", 32'(fall_o[7]), 32'd1);
    tick();
    check("nf_fall_end", 32'(fall_o[7]), 32'd0);

    // config port boundaries and back-to-back access
    cfg_wr(NP, 8'hAA);
    cfg_rd(NP, 8'h00, "oor_rd");
    cfg_rd(NP - 1, 8'h03, "oor_nochg");
    cfg_rd(0, 8'h04, "oor_nochg0");
    cfg_wr(9, 8'h5C);
    cfg_rd(9, 8'h5C, "b2b_rd");
    tick();
    check("b2b_rvalid_off", 32'(cfg_rvalid_o), 32'd0);
    check("b2b_rdata_hold", 32'(cfg_rdata_o), 32'h5C);

    // async reset mid-cycle while driving and mid-filter
    cfg_wr(1, 8'h00);
    gpio_o_i[1] = 1'b1;
    pad_p2c_i[2] = 1'b0;
    tick();
    check("pre_rst_en", 32'(pad_c2p_en_o[1]), 32'd1);
    check("pre_rst_c2p", 32'(pad_c2p_o[1]), 32'd1);
    tick();
    #3;
    rst_i = 1'b1;
    #1;
    check("arst_c2p_en", 32'(pad_c2p_en_o), 32'd0);
    check("arst_c2p", 32'(pad_c2p_o), 32'd0);
    check("arst_gpio_i", 32'(gpio_i_o), 32'd0);
    check("arst_rvalid", 32'(cfg_rvalid_o), 32'd0);
    check("arst_rdata", 32'(cfg_rdata_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    cfg_rd(1, 8'h03, "arst_cfg1");
    cfg_rd(2, 8'h03, "arst_cfg2");
    cfg_rd(9, 8'h03, "arst_cfg9");
    tick();
    check("arst_still_safe", 32'(pad_c2p_en_o), 32'd0);
    check("arst_no_rise", 32'(rise_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
